seq_detect_sched: RTL and testbench
===================================

SEQ_DETECT_SCHED -- requirements
Module: seq_detect_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  request per requester i; held high until its gnt bit pulses.
REQ-005 din  input  32  packed bytes; requester i byte at din[8i+7:8i].
REQ-006 gnt  output  4  one-hot, one-cycle grant pulse; byte captured that cycle.
REQ-007 busy  output  1  high from grant cycle through last shift cycle.
REQ-008 done  output  1  one-cycle pulse when a byte finishes.
REQ-009 done_id  output  2  index of finished requester; valid with done, held until next done.
REQ-010 match_cnt  output  4  pattern matches in finished byte; valid with done, held until next done.

Function
REQ-011 FSM states SHALL be IDLE, GRANT, SHIFT, DONE; all outputs registered.
REQ-012 IDLE: any req bit high at a clk edge -> GRANT next cycle; no req -> stay IDLE.
REQ-013 GRANT (1 cycle): gnt[w]=1 for winner w, din byte w latched to shift register, detector history and match counter cleared, busy=1.
REQ-014 SHIFT (exactly 8 cycles): one bit per cycle, MSB (bit 7) first, into the embedded serial detector; busy=1.
REQ-015 Detector SHALL flag overlapping occurrences of serial pattern 1011; each flag increments the match counter by 1.
REQ-016 Detector history SHALL NOT carry across bytes.
REQ-017 DONE (1 cycle): done=1, done_id=w, match_cnt=count, busy=0; then IDLE.
REQ-018 Latency: req seen at edge N -> gnt during cycle N+1, shifts N+2..N+9, done during N+10; IDLE at N+11, earliest next gnt N+12.
REQ-019 Arbitration SHALL be round-robin: search starts at pointer p; after grant to w, p=(w+1) mod 4.
REQ-020 req changes after grant SHALL be ignored until the next IDLE.
REQ-021 din changes after the grant cycle SHALL NOT affect the byte in progress.
REQ-022 match_cnt SHALL NOT wrap (max possible count per byte is 2).
REQ-023 gnt SHALL never have more than one bit set; no gnt outside GRANT.

Reset
REQ-024 reset high at a clk edge SHALL force IDLE, gnt=0, busy=0, done=0, done_id=0, match_cnt=0, p=0, shift register and detector cleared.
REQ-025 Reset during GRANT/SHIFT/DONE SHALL abandon the byte with no done pulse.
REQ-026 reset SHALL take priority over all requests in the same cycle.

Configuration
REQ-027 Macro SCHED_PRIO_EN SHALL select arbitration.
REQ-028 Defined: fixed priority, req[0] highest, req[3] lowest; pointer unused.
REQ-029 Undefined: round-robin per REQ-019.

Verification
REQ-030 req=4'b0001, din[7:0]=8'hB6 -> gnt=4'b0001 one cycle, done 9 cycles later, done_id=0, match_cnt=2.
REQ-031 req=4'b0100, din[23:16]=8'hFF, then 8'h00 -> match_cnt=0 both times, done_id=2.
REQ-032 req=4'b1111 held, no macro -> grants in order 0,1,2,3,0; one done per grant, 11 cycles apart.
REQ-033 Same stimulus with SCHED_PRIO_EN -> every grant to requester 0.
REQ-034 reset high on 4th SHIFT cycle -> next cycle busy=0, gnt=0, match_cnt=0, no done pulse; next req grants requester 0 first.
REQ-035 din[7:0] switched from 8'hB6 to 8'h00 the cycle after gnt -> match_cnt=2.

Source files
------------

// File: rtl/seq_detect_sched.sv
// Arbitrated byte scheduler feeding a serial "1011" detector (overlapping, MSB first).
// Define SCHED_PRIO_EN for fixed priority (req[0] highest); round-robin otherwise.
module seq_detect_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] din,
  output logic [3:0]  gnt,
  output logic        busy,
  output logic        done,
  output logic [1:0]  done_id,
  output logic [3:0]  match_cnt
);
  // Handshake: a requester holds req[i] high until it sees gnt[i] pulse for one
  // cycle; its byte is taken from din during that grant cycle, and req/din are
  // ignored from then until the scheduler is back in IDLE.
  typedef enum logic [1:0] {IDLE, GRANT, SHIFT, DONE} state_t;

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [1:0] win, win_n;
  logic [7:0] shreg, shreg_n;
  logic [2:0] hist, hist_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] bitc, bitc_n;
  logic [3:0] gnt_n;
  logic       busy_n, done_n;
  logic [1:0] done_id_n;
  logic [3:0] match_n;
  logic [1:0] pick;
  logic       hit;

`ifdef SCHED_PRIO_EN
  always_comb begin
    pick = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (req[k]) pick = k[1:0];
  end
`else
  logic       rr_found;
  logic [1:0] rr_idx;

  always_comb begin
    pick     = 2'd0;
    rr_found = 1'b0;
    rr_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      rr_idx = ptr + k[1:0];
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        pick     = rr_idx;
      end
    end
  end
`endif

  // History starts at zero each byte; a leading zero can never complete 1011.
  assign hit = ({hist, shreg[7]} == 4'b1011);

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    win_n     = win;
    shreg_n   = shreg;
    hist_n    = hist;
    cnt_n     = cnt;
    bitc_n    = bitc;
    gnt_n     = 4'b0000;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    done_id_n = done_id;
    match_n   = match_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = GRANT;
          win_n   = pick;
          gnt_n   = 4'b0001 << pick;
          busy_n  = 1'b1;
          ptr_n   = pick + 2'd1;
        end
      end
      GRANT: begin
        state_n = SHIFT;
        shreg_n = din[{win, 3'b000} +: 8];
        hist_n  = 3'b000;
        cnt_n   = 4'd0;
        bitc_n  = 3'd0;
        busy_n  = 1'b1;
      end
      SHIFT: begin
        shreg_n = {shreg[6:0], 1'b0};
        hist_n  = {hist[1:0], shreg[7]};
        cnt_n   = cnt + {3'b000, hit};
        bitc_n  = bitc + 3'd1;
        busy_n  = 1'b1;
        if (bitc == 3'd7) begin
          state_n   = DONE;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          done_id_n = win;
          match_n   = cnt + {3'b000, hit};
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      win       <= 2'd0;
      shreg     <= 8'd0;
      hist      <= 3'd0;
      cnt       <= 4'd0;
      bitc      <= 3'd0;
      gnt       <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= 2'd0;
      match_cnt <= 4'd0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      win       <= win_n;
      shreg     <= shreg_n;
      hist      <= hist_n;
      cnt       <= cnt_n;
      bitc      <= bitc_n;
      gnt       <= gnt_n;
      busy      <= busy_n;
      done      <= done_n;
      done_id   <= done_id_n;
      match_cnt <= match_n;
    end
  end
endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched: directed vector table, randomized transactions
// against a pattern-counting/arbitration model, and reset/back-to-back sequences.
module tb_seq_detect_sched;
  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic [3:0]  match_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int p_model = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  exp_gnt;
    logic [1:0]  exp_id;
    logic [3:0]  exp_cnt;
    logic        scramble;
  } vec_t;

  vec_t vecs[8];

  seq_detect_sched dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .gnt(gnt), .busy(busy),
    .done(done), .done_id(done_id), .match_cnt(match_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    p_model = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: count windows equal to 1011 reading MSB first
  function automatic int count_1011(input logic [7:0] b);
    int c = 0;
    for (int i = 7; i >= 3; i--)
      if (b[i] && !b[i-1] && b[i-2] && b[i-3]) c++;
    return c;
  endfunction

  function automatic int model_pick(input logic [3:0] r);
    int w = 0;
`ifdef SCHED_PRIO_EN
    for (int k = 3; k >= 0; k--) if (r[k]) w = k;
`else
    for (int k = 3; k >= 0; k--) if (r[(p_model + k) % 4]) w = (p_model + k) % 4;
`endif
    return w;
  endfunction

  // driver: one full byte transaction starting from IDLE (or DONE)
  task automatic run_byte(input logic [3:0] r, input logic [31:0] d, input bit drop,
                          input bit scramble, input logic [3:0] eg, input logic [1:0] eid,
                          input logic [3:0] ec);
    int n;
    int bad;
    req = r;
    din = d;
    n = 0;
    while (gnt == 4'b0000 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    check("gnt", gnt, eg);
    check("busy_at_gnt", busy, 1);
    if (drop) req = 4'b0000;
    n = 0;
    bad = 0;
    while (!done && n < 30) begin
      @(posedge clk); #1; n++;
      if (scramble && !done) begin
        din = $urandom;
        if (drop) req = 4'($urandom);
      end
      if (!done && (!busy || gnt != 4'b0000)) bad++;
    end
    if (drop) req = 4'b0000;
    check("done_latency", n, 9);
    check("busy_shift", bad, 0);
    check("done_id", done_id, eid);
    check("match_cnt", match_cnt, ec);
    check("busy_at_done", busy, 0);
    last_done_cyc = cyc;
  endtask

  initial begin
    int w;
    logic [3:0]  r;
    logic [31:0] d;
    bit          scr;
    int          n;
    int          seen_done;

    req = 4'b0000;
    din = 32'h0;
    do_reset();

    // reset state
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_match_cnt", match_cnt, 0);

    // directed table (pointer evolves from 0 after reset)
    vecs[0] = '{4'b0001, 32'h000000B6, 4'b0001, 2'd0, 4'd2, 1'b0};
    vecs[1] = '{4'b0100, 32'h00FF0000, 4'b0100, 2'd2, 4'd0, 1'b0};
    vecs[2] = '{4'b0100, 32'hB600B6B6, 4'b0100, 2'd2, 4'd0, 1'b0};
    vecs[3] = '{4'b0001, 32'h000000B6, 4'b0001, 2'd0, 4'd2, 1'b1};
`ifdef SCHED_PRIO_EN
    vecs[4] = '{4'b0011, 32'h00005BFF, 4'b0001, 2'd0, 4'd0, 1'b0};
    vecs[5] = '{4'b1001, 32'hBB000000, 4'b0001, 2'd0, 4'd0, 1'b0};
`else
    vecs[4] = '{4'b0011, 32'h00005BFF, 4'b0010, 2'd1, 4'd2, 1'b0};
    vecs[5] = '{4'b1001, 32'hBB000000, 4'b1000, 2'd3, 4'd2, 1'b0};
`endif
    vecs[6] = '{4'b1010, 32'h00000B00, 4'b0010, 2'd1, 4'd1, 1'b0};
    vecs[7] = '{4'b0001, 32'hB6B6B62D, 4'b0001, 2'd0, 4'd1, 1'b0};
    for (int i = 0; i < 8; i++)
      run_byte(vecs[i].req, vecs[i].din, 1'b1, vecs[i].scramble,
               vecs[i].exp_gnt, vecs[i].exp_id, vecs[i].exp_cnt);

    // randomized transactions against the model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      r   = 4'($urandom_range(1, 15));
      d   = $urandom;
      scr = 1'($urandom_range(0, 1));
      w   = model_pick(r);
      run_byte(r, d, 1'b1, scr, 4'(1 << w), 2'(w), 4'(count_1011(d[8*w +: 8])));
      p_model = (w + 1) % 4;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    // all requesters held: round-robin order and 11-cycle done spacing
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      w = model_pick(4'b1111);
      run_byte(4'b1111, d, 1'b0, 1'b0, 4'(1 << w), 2'(w), 4'(count_1011(d[8*w +: 8])));
      if (i > 0) check("done_spacing", cyc - n, 11);
      n = cyc;
      p_model = (w + 1) % 4;
    end
    req = 4'b0000;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // reset on the 4th shift cycle abandons the byte
    run_byte(4'b0001, 32'h000000B6, 1'b1, 1'b0, 4'b0001, 2'd0, 4'd2);
    @(posedge clk); #1;
    req = 4'b0010;
    din = 32'h0000B600;
    n = 0;
    while (gnt == 4'b0000 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    check("abort_gnt", gnt, 4'b0010);
    req = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    p_model = 0;
    check("abort_busy", busy, 0);
    check("abort_gnt0", gnt, 0);
    check("abort_match_cnt", match_cnt, 0);
    check("abort_done", done, 0);
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    check("abort_no_done", seen_done, 0);
    run_byte(4'b1111, 32'hB6B6B6B6, 1'b1, 1'b0, 4'b0001, 2'd0, 4'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
